vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 13 +
 rtl/vga_timing_gen_pix_tick.sv | 20 ++
 rtl/vga_timing_gen.sv | 72 +++++++
 tb/tb_vga_timing_gen.sv | 124 ++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster constants for the timing generator and window detector.
package vga_timing_pkg;
    localparam int H_TOTAL      = 800;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int H_ACTIVE     = 640;
    localparam int V_TOTAL      = 525;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_ACTIVE     = 480;
    localparam int H_DISP_START = H_SYNC + H_BACK;
    localparam int V_DISP_START = V_SYNC + V_BACK;
endpackage

// File: rtl/vga_timing_gen_pix_tick.sv
// pix_tick_gen: divides CLK by CLK_DIV and flags the last CLK cycle of each pixel.
module pix_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic CLK,
    input  logic RST,
    output logic pix_tick
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    assign pix_tick = div_cnt == LAST;

    always_ff @(posedge CLK)
        div_cnt <= (RST || pix_tick) ? '0 : div_cnt + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, active-low HSYNC/VSYNC and line/frame strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 6-bit frame counter and blink output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
    parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int V_TOTAL = vga_timing_pkg::V_TOTAL,
    parameter int V_SYNC  = vga_timing_pkg::V_SYNC
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [9:0] horiz_c,
    output logic [9:0] vert_c,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       pix_tick,
    output logic       line_end,
    output logic       frame_end
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [5:0] frame_cnt,
    output logic       blink
`endif
);
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit 10-bit counters");
    end

    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SW  = 10'(H_SYNC);
    localparam logic [9:0] V_SW  = 10'(V_SYNC);

    logic [9:0] h_nxt, v_nxt;

    pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick (
        .CLK     (CLK),
        .RST     (RST),
        .pix_tick(pix_tick)
    );

    always_comb begin
        line_end  = pix_tick && horiz_c == H_MAX;
        frame_end = line_end && vert_c == V_MAX;
        h_nxt     = pix_tick ? (horiz_c == H_MAX ? '0 : horiz_c + 10'd1) : horiz_c;
        v_nxt     = line_end ? (vert_c == V_MAX ? '0 : vert_c + 10'd1) : vert_c;
    end

    // Syncs decode the next-state counters so pins and counters change on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            horiz_c <= '0;
            vert_c  <= '0;
            HSYNC   <= 1'b0;
            VSYNC   <= 1'b0;
        end else begin
            horiz_c <= h_nxt;
            vert_c  <= v_nxt;
            HSYNC   <= h_nxt >= H_SW;
            VSYNC   <= v_nxt >= V_SW;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge CLK)
        frame_cnt <= RST ? '0 : frame_cnt + 6'(frame_end);

    assign blink = frame_cnt[5];
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench comparing three parameterisations against an arithmetic raster model.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       pt;
        logic       le;
        logic       fe;
        logic [5:0] fc;
        logic       bl;
    } obs_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    obs_t oa, ob, oc;
    obs_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    vga_timing_gen dut_a (
        .CLK(CLK), .RST(RST), .horiz_c(oa.h), .vert_c(oa.v), .HSYNC(oa.hs), .VSYNC(oa.vs),
        .pix_tick(oa.pt), .line_end(oa.le), .frame_end(oa.fe)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(oa.fc), .blink(oa.bl)
`endif
    );

    vga_timing_gen #(.CLK_DIV(3), .H_TOTAL(10), .H_SYNC(3), .V_TOTAL(5), .V_SYNC(2)) dut_b (
        .CLK(CLK), .RST(RST), .horiz_c(ob.h), .vert_c(ob.v), .HSYNC(ob.hs), .VSYNC(ob.vs),
        .pix_tick(ob.pt), .line_end(ob.le), .frame_end(ob.fe)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(ob.fc), .blink(ob.bl)
`endif
    );

    vga_timing_gen #(.CLK_DIV(1), .H_TOTAL(8), .H_SYNC(2), .V_TOTAL(4), .V_SYNC(1)) dut_c (
        .CLK(CLK), .RST(RST), .horiz_c(oc.h), .vert_c(oc.v), .HSYNC(oc.hs), .VSYNC(oc.vs),
        .pix_tick(oc.pt), .line_end(oc.le), .frame_end(oc.fe)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(oc.fc), .blink(oc.bl)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Position derived from CLKs elapsed since reset rather than by stepping counters.
    function automatic obs_t model(input int t, input int d, input int ht, input int hs, input int vt, input int vs);
        obs_t m;
        int p, h, v;
        p    = t / d;
        h    = p % ht;
        v    = (p / ht) % vt;
        m.h  = 10'(h);
        m.v  = 10'(v);
        m.hs = h >= hs;
        m.vs = v >= vs;
        m.pt = (t % d) == d - 1;
        m.le = m.pt && h == ht - 1;
        m.fe = m.le && v == vt - 1;
        m.fc = 6'((p / (ht * vt)) % 64);
        m.bl = m.fc[5];
        return m;
    endfunction

    task automatic cmp(input string p, input obs_t g, input obs_t e);
        chk({p, "_horiz_c"}, 32'(g.h), 32'(e.h));
        chk({p, "_vert_c"}, 32'(g.v), 32'(e.v));
        chk({p, "_HSYNC"}, 32'(g.hs), 32'(e.hs));
        chk({p, "_VSYNC"}, 32'(g.vs), 32'(e.vs));
        chk({p, "_pix_tick"}, 32'(g.pt), 32'(e.pt));
        chk({p, "_line_end"}, 32'(g.le), 32'(e.le));
        chk({p, "_frame_end"}, 32'(g.fe), 32'(e.fe));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk({p, "_frame_cnt"}, 32'(g.fc), 32'(e.fc));
        chk({p, "_blink"}, 32'(g.bl), 32'(e.bl));
`endif
    endtask

    initial begin
        int   t = 0;
        int   a_le = 0;
        int   b_fe = 0;
        int   b_t0 = 0;
        bit   mid_done = 0;
        obs_t e;
        for (int n = 0; n < 12400; n++) begin
            @(posedge CLK);
            t = RST ? 0 : t + 1;
            q.push_back(model(t, 2, 800, 96, 525, 2));
            q.push_back(model(t, 3, 10, 3, 5, 2));
            q.push_back(model(t, 1, 8, 2, 4, 1));
            #1;
            e = q.pop_front();
            cmp("a", oa, e);
            e = q.pop_front();
            cmp("b", ob, e);
            e = q.pop_front();
            cmp("c", oc, e);
            if (!mid_done && t >= 1 && t <= 1600 && oa.le === 1'b1) a_le++;
            if (!mid_done && t == 1600) chk("a_line_ends_first_line", 32'(a_le), 32'd1);
            if (mid_done && oa.pt === 1'b1 && RST == 1'b0) b_t0 = b_t0;
            if (mid_done && ob.fe === 1'b1) b_fe++;
            // Mid-line reset lands with dut_a at horiz_c=400, vert_c=1.
            RST = n < 2 || (!mid_done && t == 2400);
            if (RST && n >= 2) begin
                mid_done = 1;
                b_t0 = n;
            end
        end
        chk("b_frame_ends_after_mid_reset", 32'(b_fe), 32'((12399 - b_t0) / 150));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
